// File: rtl/ifu_mem_arb.sv
// rtl/ifu_mem_arb.sv - instruction ROM read-port arbiter between the fetch path and the LSU/debug read path.
// LS normally wins; a saturating starvation counter forces an IF grant after STARVE_MAX LS wins.
module ifu_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  input  logic              flush_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              hold_o
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } own_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  own_e       own_q, own_d;
  logic [3:0] starve_q, starve_d;
  logic       kill_q, kill_d;
  logic       if_wins;

  // Grant decode; everything is forced low while rst is high so no read is issued in reset.
  always_comb begin
    if_wins    = if_req_i & (~ls_req_i | (starve_q == STARVE_LIM));
    if_gnt_o   = ~rst & if_wins;
    ls_gnt_o   = ~rst & ls_req_i & ~if_wins;
    mem_en_o   = if_gnt_o | ls_gnt_o;
    mem_addr_o = '0;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
    end else if (ls_gnt_o) begin
      mem_addr_o = ls_addr_i;
    end
    hold_o = ~rst & if_req_i & ~if_gnt_o;
  end

  always_comb begin
    own_d    = OWN_NONE;
    starve_d = starve_q;
    kill_d   = flush_i & if_gnt_o;
    if (if_gnt_o) begin
      own_d = OWN_IF;
    end else if (ls_gnt_o) begin
      own_d = OWN_LS;
    end
    if (if_gnt_o || !if_req_i) begin
      starve_d = 4'd0;
    end else if (ls_gnt_o && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q    <= OWN_NONE;
      starve_q <= 4'd0;
      kill_q   <= 1'b0;
    end else begin
      own_q    <= own_d;
      starve_q <= starve_d;
      kill_q   <= kill_d;
    end
  end

  // A flush in the response cycle drops the fetch data; LS data is never affected.
  always_comb begin
    if_rvalid_o = ~rst & (own_q == OWN_IF) & ~kill_q & ~flush_i;
    ls_rvalid_o = ~rst & (own_q == OWN_LS);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_ifu_mem_arb.sv
// tb/tb_ifu_mem_arb.sv - table-driven directed bench for ifu_mem_arb with a behavioural ROM.
module tb_ifu_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, flush;
  logic [31:0] if_addr, ls_addr;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, hold;
  logic [31:0] if_rdata, ls_rdata, mem_addr;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifu_mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_gnt_o   (if_gnt),
    .if_rvalid_o(if_rvalid),
    .if_rdata_o (if_rdata),
    .ls_req_i   (ls_req),
    .ls_addr_i  (ls_addr),
    .ls_gnt_o   (ls_gnt),
    .ls_rvalid_o(ls_rvalid),
    .ls_rdata_o (ls_rdata),
    .flush_i    (flush),
    .mem_en_o   (mem_en),
    .mem_addr_o (mem_addr),
    .mem_rdata_i(mem_rdata),
    .hold_o     (hold)
  );

  function automatic logic [31:0] rom(input logic [31:0] word);
    return {16'hC0DE, word[15:0]};
  endfunction

  // ROM with one-cycle read latency; data is left stale when not enabled.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom(mem_addr >> 2);
  end

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        flush;
    logic        e_ifg;
    logic        e_lsg;
    logic        e_hold;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_lsv;
    logic [31:0] e_lsd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iq, input logic [31:0] ia,
                              input logic lq, input logic [31:0] la, input logic fl,
                              input logic gi, input logic gl, input logic h,
                              input logic iv, input logic [31:0] id,
                              input logic lv, input logic [31:0] ld);
    vec_t v;
    v.rst = r; v.if_req = iq; v.if_addr = ia; v.ls_req = lq; v.ls_addr = la; v.flush = fl;
    v.e_ifg = gi; v.e_lsg = gl; v.e_hold = h;
    v.e_ifv = iv; v.e_ifd = id; v.e_lsv = lv; v.e_lsd = ld;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int step);
    logic [31:0] e_addr;
    @(posedge clk);
    #1;
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
    ls_req = v.ls_req; ls_addr = v.ls_addr; flush = v.flush;
    #1;
    e_addr = v.e_ifg ? v.if_addr : (v.e_lsg ? v.ls_addr : 32'h0);
    chk("if_gnt",    step, {31'b0, if_gnt},    {31'b0, v.e_ifg});
    chk("ls_gnt",    step, {31'b0, ls_gnt},    {31'b0, v.e_lsg});
    chk("hold",      step, {31'b0, hold},      {31'b0, v.e_hold});
    chk("mem_en",    step, {31'b0, mem_en},    {31'b0, v.e_ifg | v.e_lsg});
    chk("mem_addr",  step, mem_addr,           e_addr);
    chk("if_rvalid", step, {31'b0, if_rvalid}, {31'b0, v.e_ifv});
    chk("if_rdata",  step, if_rdata,           v.e_ifd);
    chk("ls_rvalid", step, {31'b0, ls_rvalid}, {31'b0, v.e_lsv});
    chk("ls_rdata",  step, ls_rdata,           v.e_lsd);
  endtask

  vec_t tbl[$];
  vec_t z;

  initial begin
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; flush = 1'b0;
    if_addr = 32'h0; ls_addr = 32'h0;

    // Reset with requests pending: nothing granted, every output low.
    apply(mk(1, 1, 32'h4, 1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    apply(mk(1, 1, 32'h4, 1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0), 101);
    apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0), 102);

    // Fetch stream
    tbl.push_back(mk(0, 1, 32'h00, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h04, 0, 32'h0, 0, 1, 0, 0, 1, rom(0), 0, 0));
    tbl.push_back(mk(0, 1, 32'h08, 0, 32'h0, 0, 1, 0, 0, 1, rom(1), 0, 0));
    tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0, 0, 0, 0, 0, 1, rom(2), 0, 0));
    // IF and LS collide: LS wins, fetch held
    tbl.push_back(mk(0, 1, 32'h10, 1, 32'h100, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,   0, 0, 0, 0, 0, 0, 1, rom(32'h40)));
    // Starvation: LS,LS,LS,LS,IF,LS,LS,LS
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h200, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h204, 0, 0, 1, 1, 0, 0, 1, rom(32'h80)));
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h208, 0, 0, 1, 1, 0, 0, 1, rom(32'h81)));
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h20C, 0, 0, 1, 1, 0, 0, 1, rom(32'h82)));
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h210, 0, 1, 0, 0, 0, 0, 1, rom(32'h83)));
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h214, 0, 0, 1, 1, 1, rom(32'hC), 0, 0));
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h218, 0, 0, 1, 1, 0, 0, 1, rom(32'h85)));
    tbl.push_back(mk(0, 1, 32'h30, 1, 32'h21C, 0, 0, 1, 1, 0, 0, 1, rom(32'h86)));
    tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,   0, 0, 0, 0, 0, 0, 1, rom(32'h87)));
    // Flush in the grant cycle kills that fetch; the next fetch returns normally
    tbl.push_back(mk(0, 1, 32'h20, 0, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h80, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0, 0, 0, 0, 0, 1, rom(32'h20), 0, 0));
    // Flush in the response cycle drops IF data; LS response under flush survives
    tbl.push_back(mk(0, 1, 32'h40, 0, 32'h0,   0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h00, 1, 32'h300, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,   1, 0, 0, 0, 0, 0, 1, rom(32'hC0)));
    tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset mid-stream with an LS read outstanding and the starvation counter at 3
    apply(mk(0, 1, 32'h50, 1, 32'h400, 0, 0, 1, 1, 0, 0, 0, 0), 200);
    apply(mk(0, 1, 32'h50, 1, 32'h404, 0, 0, 1, 1, 0, 0, 1, rom(32'h100)), 201);
    apply(mk(0, 1, 32'h50, 1, 32'h408, 0, 0, 1, 1, 0, 0, 1, rom(32'h101)), 202);
    apply(mk(1, 1, 32'h50, 1, 32'h40C, 0, 0, 0, 0, 0, 0, 0, 0), 203);
    apply(mk(0, 0, 32'h00, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0), 204);
    // Counter restarted from 0: four LS wins before IF gets through
    apply(mk(0, 1, 32'h60, 1, 32'h500, 0, 0, 1, 1, 0, 0, 0, 0), 205);
    apply(mk(0, 1, 32'h60, 1, 32'h504, 0, 0, 1, 1, 0, 0, 1, rom(32'h140)), 206);
    apply(mk(0, 1, 32'h60, 1, 32'h508, 0, 0, 1, 1, 0, 0, 1, rom(32'h141)), 207);
    apply(mk(0, 1, 32'h60, 1, 32'h50C, 0, 0, 1, 1, 0, 0, 1, rom(32'h142)), 208);
    apply(mk(0, 1, 32'h60, 1, 32'h510, 0, 1, 0, 0, 0, 0, 1, rom(32'h143)), 209);
    z = mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 1, rom(32'h18), 0, 0);
    apply(z, 210);
    apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0), 211);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
